// File: rtl/mac_pkg.sv
// Shared constants and width helpers for the MAC stream blocks.
// Imported by the formatter and the accumulating top level.
package mac_pkg;

    localparam int MAC_SAT   = 1;
    localparam int MAC_TRUNC = 0;

    // Ceiling log2; clog2(1) = 0, clog2(4) = 2, clog2(5) = 3.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // Accumulator width that cannot overflow over max_len beats of a*c + b*c.
    function automatic int acc_width(input int dw, input int max_len);
        return 2 * dw + 1 + clog2(max_len);
    endfunction

    // Width needed to hold a beat count of 0..max_len.
    function automatic int beat_width(input int max_len);
        return clog2(max_len + 1);
    endfunction

endpackage

// File: rtl/mac_out_fmt.sv
// Combinational accumulator-to-output formatter: saturate or truncate,
// and flag sums that do not fit in OUT_WIDTH bits.
module mac_out_fmt
    import mac_pkg::*;
#(
    parameter int ACC_W     = 19,
    parameter int OUT_WIDTH = 8,
    parameter int SAT_MODE  = MAC_SAT
) (
    input  logic [ACC_W-1:0]     acc,
    output logic [OUT_WIDTH-1:0] data,
    output logic                 sat
);

    generate
        if (ACC_W > OUT_WIDTH) begin : g_narrow
            logic over;
            // Any bit above the output field means acc > 2^OUT_WIDTH-1.
            assign over = |acc[ACC_W-1:OUT_WIDTH];
            assign sat  = over;
            if (SAT_MODE == MAC_SAT) begin : g_sat
                assign data = over ? {OUT_WIDTH{1'b1}} : acc[OUT_WIDTH-1:0];
            end else begin : g_trunc
                assign data = acc[OUT_WIDTH-1:0];
            end
        end else begin : g_wide
            // Output wide enough for any sum: never saturates.
            assign sat  = 1'b0;
            assign data = OUT_WIDTH'(acc);
        end
    endgenerate

endmodule

// File: rtl/mac_accum_stream.sv
// Streaming MAC: per beat a*c + b*c, accumulated over a group of up to
// MAX_LEN beats, one formatted result per group on a valid/ready output.
module mac_accum_stream
    import mac_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int MAX_LEN    = 4,
    parameter int OUT_WIDTH  = 8,
    parameter int SAT_MODE   = MAC_SAT
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [DATA_WIDTH-1:0]           s_a_data,
    input  logic [DATA_WIDTH-1:0]           s_b_data,
    input  logic [DATA_WIDTH-1:0]           s_c_data,
    input  logic                            s_valid,
    input  logic                            s_last,
    output logic                            s_ready,
    output logic [OUT_WIDTH-1:0]            m_data,
    output logic                            m_sat,
    output logic [beat_width(MAX_LEN)-1:0]  m_beats,
    output logic                            m_valid,
    input  logic                            m_ready
);

    localparam int ACC_W = acc_width(DATA_WIDTH, MAX_LEN);
    localparam int BW    = beat_width(MAX_LEN);
    localparam int PW    = 2 * DATA_WIDTH;

    logic              en;
    logic [BW-1:0]     cnt;
    logic [BW-1:0]     beat_no;
    logic              close;
    logic [PW-1:0]     pa_c;
    logic [PW-1:0]     pb_c;

    logic              p_valid;
    logic              p_first;
    logic              p_last;
    logic [BW-1:0]     p_beats;
    logic [PW-1:0]     p_pa;
    logic [PW-1:0]     p_pb;

    logic              a_valid;
    logic              a_last;
    logic [BW-1:0]     a_beats;
    logic [ACC_W-1:0]  acc;
    logic [ACC_W-1:0]  beat_sum;

    logic [OUT_WIDTH-1:0] fmt_data;
    logic                 fmt_sat;

    // Whole pipeline advances together; stalls only on a held result.
    assign en      = !m_valid || m_ready;
    assign s_ready = en;

    assign beat_no = cnt + BW'(1);
    assign close   = s_last || (beat_no == BW'(MAX_LEN));
    assign pa_c    = PW'(s_a_data) * PW'(s_c_data);
    assign pb_c    = PW'(s_b_data) * PW'(s_c_data);

    assign beat_sum = ACC_W'(p_pa) + ACC_W'(p_pb);

    // Stage P: register products and group position; track beat count.
    always_ff @(posedge clk) begin
        if (rst) begin
            p_valid <= 1'b0;
            p_first <= 1'b0;
            p_last  <= 1'b0;
            p_beats <= '0;
            p_pa    <= '0;
            p_pb    <= '0;
            cnt     <= '0;
        end else if (en) begin
            p_valid <= s_valid;
            if (s_valid) begin
                p_pa    <= pa_c;
                p_pb    <= pb_c;
                p_first <= (cnt == '0);
                p_last  <= close;
                p_beats <= beat_no;
                cnt     <= close ? '0 : beat_no;
            end
        end
    end

    // Stage A: accumulate, restarting on the first beat of each group.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_valid <= 1'b0;
            a_last  <= 1'b0;
            a_beats <= '0;
            acc     <= '0;
        end else if (en) begin
            a_valid <= p_valid;
            if (p_valid) begin
                acc     <= (p_first ? '0 : acc) + beat_sum;
                a_last  <= p_last;
                a_beats <= p_beats;
            end
        end
    end

    mac_out_fmt #(
        .ACC_W     (ACC_W),
        .OUT_WIDTH (OUT_WIDTH),
        .SAT_MODE  (SAT_MODE)
    ) u_fmt (
        .acc  (acc),
        .data (fmt_data),
        .sat  (fmt_sat)
    );

    // Output register: loads only on a group's final beat, holds while stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            m_valid <= 1'b0;
            m_data  <= '0;
            m_sat   <= 1'b0;
            m_beats <= '0;
        end else if (en) begin
            m_valid <= a_valid && a_last;
            if (a_valid && a_last) begin
                m_data  <= fmt_data;
                m_sat   <= fmt_sat;
                m_beats <= a_beats;
            end
        end
    end

endmodule

// File: tb/tb_mac_accum_stream.sv
// Bench for mac_accum_stream: three instances (saturating, truncating,
// 19-bit wide) share one stimulus and are checked against a group model.
module tb_mac_accum_stream;
    import mac_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] s_a, s_b, s_c;
    logic       s_valid, s_last, m_ready;

    logic        sr0, sr1, sr2, mv0, mv1, mv2, ms0, ms1, ms2;
    logic [7:0]  md0, md1;
    logic [18:0] md2;
    logic [2:0]  mb0, mb1, mb2;

    logic [18:0] md[3];
    logic [2:0]  mb[3];
    logic        ms[3], mv[3], sr[3];

    int checks = 0;
    int errors = 0;

    longint exp_sum[64];
    int     exp_beats[64];
    int     wr_idx = 0;
    int     rd_idx[3] = '{0, 0, 0};
    longint msum = 0;
    int     mbeats = 0;

    longint last_data[3];
    int     last_beats[3];
    int     last_sat[3];
    bit     held[3] = '{0, 0, 0};
    longint hd[3];
    int     hb[3], hs[3];
    int     run = 0;
    int     max_run = 0;

    always #5 clk = ~clk;

    mac_accum_stream #(.DATA_WIDTH(8), .MAX_LEN(4), .OUT_WIDTH(8),
                       .SAT_MODE(MAC_SAT)) u_sat (
        .clk(clk), .rst(rst), .s_a_data(s_a), .s_b_data(s_b),
        .s_c_data(s_c), .s_valid(s_valid), .s_last(s_last),
        .s_ready(sr0), .m_data(md0), .m_sat(ms0), .m_beats(mb0),
        .m_valid(mv0), .m_ready(m_ready));

    mac_accum_stream #(.DATA_WIDTH(8), .MAX_LEN(4), .OUT_WIDTH(8),
                       .SAT_MODE(MAC_TRUNC)) u_trunc (
        .clk(clk), .rst(rst), .s_a_data(s_a), .s_b_data(s_b),
        .s_c_data(s_c), .s_valid(s_valid), .s_last(s_last),
        .s_ready(sr1), .m_data(md1), .m_sat(ms1), .m_beats(mb1),
        .m_valid(mv1), .m_ready(m_ready));

    mac_accum_stream #(.DATA_WIDTH(8), .MAX_LEN(4), .OUT_WIDTH(19),
                       .SAT_MODE(MAC_SAT)) u_wide (
        .clk(clk), .rst(rst), .s_a_data(s_a), .s_b_data(s_b),
        .s_c_data(s_c), .s_valid(s_valid), .s_last(s_last),
        .s_ready(sr2), .m_data(md2), .m_sat(ms2), .m_beats(mb2),
        .m_valid(mv2), .m_ready(m_ready));

    always_comb begin
        md[0] = 19'(md0); md[1] = 19'(md1); md[2] = md2;
        mb[0] = mb0;      mb[1] = mb1;      mb[2] = mb2;
        ms[0] = ms0;      ms[1] = ms1;      ms[2] = ms2;
        mv[0] = mv0;      mv[1] = mv1;      mv[2] = mv2;
        sr[0] = sr0;      sr[1] = sr1;      sr[2] = sr2;
    end

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Expected output word for instance k given the exact group sum.
    function automatic longint exp_data(input int k, input longint sum);
        int     ow;
        longint maxv;
        ow   = (k == 2) ? 19 : 8;
        maxv = (64'sd1 <<< ow) - 1;
        if (sum > maxv) return (k == 1) ? (sum & maxv) : maxv;
        return sum;
    endfunction

    function automatic longint exp_sat(input int k, input longint sum);
        int ow;
        ow = (k == 2) ? 19 : 8;
        return (sum > ((64'sd1 <<< ow) - 1)) ? 1 : 0;
    endfunction

    // Group model: sums accepted beats, closes on s_last or the 4th beat.
    always @(posedge clk) begin
        if (rst) begin
            msum   = 0;
            mbeats = 0;
        end else if (s_valid && sr0) begin
            msum = msum + longint'(s_a) * longint'(s_c)
                        + longint'(s_b) * longint'(s_c);
            mbeats++;
            if (s_last || mbeats == 4) begin
                exp_sum[wr_idx]   = msum;
                exp_beats[wr_idx] = mbeats;
                wr_idx++;
                msum   = 0;
                mbeats = 0;
            end
        end
    end

    // Compare every cycle: handshake, hold-stability, and each delivered result.
    always @(negedge clk) begin
        if (rst) begin
            for (int k = 0; k < 3; k++) held[k] = 0;
            run = 0;
        end else begin
            for (int k = 0; k < 3; k++) begin
                check($sformatf("s_ready[%0d]", k), sr[k], !mv[k] || m_ready);
                if (held[k]) begin
                    check($sformatf("hold_valid[%0d]", k), mv[k], 1);
                    check($sformatf("hold_data[%0d]", k), md[k], hd[k]);
                    check($sformatf("hold_beats[%0d]", k), mb[k], hb[k]);
                    check($sformatf("hold_sat[%0d]", k), ms[k], hs[k]);
                end
                held[k] = 0;
                if (mv[k] && m_ready) begin
                    if (rd_idx[k] >= wr_idx) begin
                        check($sformatf("unexpected_result[%0d]", k), 1, 0);
                    end else begin
                        check($sformatf("data[%0d]", k), md[k],
                              exp_data(k, exp_sum[rd_idx[k]]));
                        check($sformatf("sat[%0d]", k), ms[k],
                              exp_sat(k, exp_sum[rd_idx[k]]));
                        check($sformatf("beats[%0d]", k), mb[k],
                              exp_beats[rd_idx[k]]);
                        rd_idx[k]++;
                    end
                    last_data[k]  = md[k];
                    last_beats[k] = mb[k];
                    last_sat[k]   = ms[k];
                end else if (mv[k]) begin
                    held[k] = 1;
                    hd[k]   = md[k];
                    hb[k]   = mb[k];
                    hs[k]   = ms[k];
                end
            end
            run = mv[0] ? run + 1 : 0;
            if (run > max_run) max_run = run;
        end
    end

    // Present one beat and hold it until accepted (bounded).
    task automatic send(input int a, input int b, input int c, input bit last);
        bit ok;
        ok      = 0;
        s_a     = 8'(a);
        s_b     = 8'(b);
        s_c     = 8'(c);
        s_last  = last;
        s_valid = 1'b1;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            ok = sr0;
            @(posedge clk);
            #1;
            if (ok) break;
        end
        if (!ok) check("send_timeout", 0, 1);
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    // Wait until every expected result has been delivered (bounded).
    task automatic drain();
        bit done;
        done = 0;
        for (int t = 0; t < 40; t++) begin
            @(posedge clk);
            #1;
            if (rd_idx[0] == wr_idx && rd_idx[2] == wr_idx && !mv0) begin
                done = 1;
                break;
            end
        end
        check("drain", done, 1);
    endtask

    initial begin
        rst     = 1'b1;
        s_valid = 1'b0;
        s_last  = 1'b0;
        s_a     = '0;
        s_b     = '0;
        s_c     = '0;
        m_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", mv0, 0);
        check("rst_data", md0, 0);
        check("rst_beats", mb0, 0);
        check("rst_sat", ms0, 0);
        check("rst_data_wide", md2, 0);
        rst = 1'b0;

        // Single beat: 3*7 + 5*7 = 56, valid two edges after acceptance.
        send(3, 5, 7, 1);
        check("lat_edge0", mv0, 0);
        @(posedge clk); #1;
        check("lat_edge1", mv0, 0);
        @(posedge clk); #1;
        check("lat_edge2", mv0, 1);
        drain();
        check("single_data", last_data[0], 56);
        check("single_sat", last_sat[0], 0);
        check("single_beats", last_beats[0], 1);

        // Forced close after 4 beats: 4 * (30+60) = 360.
        repeat (4) send(10, 20, 3, 0);
        drain();
        check("force_sat_data", last_data[0], 255);
        check("force_sat_flag", last_sat[0], 1);
        check("force_beats", last_beats[0], 4);
        check("force_trunc_data", last_data[1], 104);
        check("force_trunc_flag", last_sat[1], 1);
        check("force_wide_data", last_data[2], 360);

        // Full precision: 4 * 2 * 255 * 255 = 520200.
        repeat (4) send(255, 255, 255, 0);
        drain();
        check("wide_data", last_data[2], 520200);
        check("wide_sat", last_sat[2], 0);
        check("wide_trunc_data", last_data[1], 8);

        // s_last on the 4th beat closes one group, then a 1-beat group.
        repeat (3) send(1, 1, 1, 0);
        send(1, 1, 1, 1);
        send(1, 0, 1, 1);
        drain();
        check("coincide_data", last_data[0], 1);
        check("coincide_beats", last_beats[0], 1);
        check("group_count", rd_idx[0], 5);

        // Backpressure: result 4*4+4*4 = 32 held for 5 cycles, then 1*3+2*3 = 9.
        m_ready = 1'b0;
        send(4, 4, 4, 1);
        for (int t = 0; t < 10; t++) begin
            if (mv0) break;
            @(posedge clk); #1;
        end
        check("bp_valid", mv0, 1);
        fork
            send(1, 2, 3, 1);
            begin
                repeat (5) begin
                    @(negedge clk);
                    check("bp_sready", sr0, 0);
                    check("bp_data", md0, 32);
                end
                @(posedge clk); #1;
                m_ready = 1'b1;
            end
        join
        drain();
        check("bp_next_data", last_data[0], 9);
        check("bp_next_beats", last_beats[0], 1);

        // Reset mid-group discards the partial sum.
        send(1, 1, 1, 0);
        send(1, 1, 1, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst_valid", mv0, 0);
        check("midrst_data", md0, 0);
        check("midrst_beats", mb0, 0);
        send(2, 0, 2, 1);
        drain();
        check("midrst_result", last_data[0], 4);
        check("midrst_result_beats", last_beats[0], 1);

        // Streaming: 8 single-beat groups, one result per cycle.
        max_run = 0;
        for (int i = 1; i <= 8; i++) send(i, 0, 1, 1);
        drain();
        check("stream_run", max_run, 8);
        check("stream_last", last_data[0], 8);
        check("stream_count", rd_idx[0], wr_idx);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
